// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined WIDTH-bit adder with carry-in and valid/ready handshake
//
// Purpose:
//   Adds A + B + Cin. The carry chain is split into STAGES chunks of CHUNK bits;
//   each pipeline stage adds one chunk and passes the carry on. Stage 0 registers
//   on the edge that accepts the operands, so a result is visible STAGES cycles
//   after the operands are presented, and one result can leave every cycle.
//   All stages advance together; when the output is stalled every stage holds.
//
// Parameters:
//   WIDTH   operand/sum width, must be a multiple of STAGES
//   STAGES  number of pipeline stages (= number of carry chunks), 1..WIDTH
//
// Ports:
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   In_Valid   in   A, B, Cin are valid
//   In_Ready   out  adder accepts operands this cycle
//   A, B       in   operands (unsigned or two's complement)
//   Cin        in   carry into bit 0
//   Out_Valid  out  Sum/Carry are valid
//   Out_Ready  in   consumer takes the result this cycle
//   Sum        out  (A + B + Cin) mod 2^WIDTH
//   Carry      out  carry out of bit WIDTH-1
//   Overflow   out  signed overflow (only with PIPELINED_ADDER_OVERFLOW_EN)
//
// Build option:
//   PIPELINED_ADDER_OVERFLOW_EN  adds the registered Overflow output.

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CHUNK = WIDTH / STAGES;
  // Only stages 0..STAGES-2 forward operands; keep at least one entry so the
  // arrays stay legal when STAGES=1.
  localparam int NOPS  = (STAGES > 1) ? STAGES - 1 : 1;

  if ((WIDTH % STAGES) != 0 || STAGES < 1) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic              advance;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [NOPS];
  logic [WIDTH-1:0]  a_d   [NOPS];
  logic [WIDTH-1:0]  b_q   [NOPS];
  logic [WIDTH-1:0]  b_d   [NOPS];

  // What each stage sees from its predecessor (stage 0 sees the input ports).
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [CHUNK:0]    chunk_res [STAGES];
  logic [STAGES-1:0] load;

  always_comb begin
    // Output slot free or being emptied: the whole pipe moves one step.
    advance = ~valid_q[STAGES-1] | Out_Ready;

    src_valid[0] = In_Valid;
    src_a[0]     = A;
    src_b[0]     = B;
    src_sum[0]   = '0;
    src_c[0]     = Cin;
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = valid_q[s-1];
      src_a[s]     = a_q[s-1];
      src_b[s]     = b_q[s-1];
      src_sum[s]   = sum_q[s-1];
      src_c[s]     = carry_q[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      chunk_res[s] = {1'b0, src_a[s][s*CHUNK +: CHUNK]}
                   + {1'b0, src_b[s][s*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_c[s]};
      // Data registers only load real work, so bubbles never pull unknown
      // operand values into the pipe.
      load[s]    = advance & src_valid[s];
      valid_d[s] = advance ? src_valid[s] : valid_q[s];
      sum_d[s]   = sum_q[s];
      carry_d[s] = carry_q[s];
      if (load[s]) begin
        sum_d[s]                    = src_sum[s];
        sum_d[s][s*CHUNK +: CHUNK]  = chunk_res[s][CHUNK-1:0];
        carry_d[s]                  = chunk_res[s][CHUNK];
      end
    end

    for (int s = 0; s < NOPS; s++) begin
      a_d[s] = a_q[s];
      b_d[s] = b_q[s];
      if (s < STAGES - 1 && load[s]) begin
        // The chunk just consumed is cleared; later stages never read it.
        a_d[s]                     = src_a[s];
        b_d[s]                     = src_b[s];
        a_d[s][s*CHUNK +: CHUNK]   = '0;
        b_d[s][s*CHUNK +: CHUNK]   = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= '0;
      end
      for (int s = 0; s < NOPS; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= sum_d[s];
      end
      for (int s = 0; s < NOPS; s++) begin
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
      end
    end
  end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (load[STAGES-1]) begin
      // Carry into the MSB is a ^ b ^ sum at that bit; overflow is that XOR carry out.
      ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
            ^ chunk_res[STAGES-1][CHUNK-1] ^ chunk_res[STAGES-1][CHUNK];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

  assign In_Ready  = advance;
  assign Out_Valid = valid_q[STAGES-1];
  assign Sum       = sum_q[STAGES-1];
  assign Carry     = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=16, STAGES=4)

module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Sum       (sum),
    .Carry     (carry)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    .Overflow  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W:0] total;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pop    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   sx, sy, sr;
    e.total = 17'(int'(x) + int'(y) + int'(c));
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = sx + sy + int'(c);
    e.ovf = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  // Scoreboard / protocol monitor, sampling at the falling edge.
  initial begin
    logic       stalled;
    logic [W:0] held;
    exp_t       e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'({carry, sum}), 32'(held));
        end
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL spurious_output: got sum %h carry %b, expected no output", sum, carry);
          end else begin
            e = exp_q.pop_front();
            check("result", 32'({carry, sum}), 32'(e.total));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            check("result_ovf", 32'(ovf), 32'(e.ovf));
`endif
            n_pop++;
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, cin));
        end
        stalled = out_valid && !out_ready;
        held    = {carry, sum};
      end
    end
  end

  task automatic single_op(input vec_t v);
    int n;
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    // n counts cycles from the one in which the operands are presented.
    while (n < 12) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 32'(n), 32'(S));
    check("vec_sum", 32'(sum), 32'(v.sum));
    check("vec_carry", 32'(carry), 32'(v.carry));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    check("vec_ovf", 32'(ovf), 32'(v.ovf));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid(input bit stall);
    out_ready = !stall;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready), stall ? 32'd0 : 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_ghost", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int   p0;
    bit   fired;

    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, carry: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sum: 16'h0001, carry: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, carry: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, carry: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 16'h8000, b: 16'hFFFF, cin: 1'b0, sum: 16'h7FFF, carry: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 16'h0001, b: 16'h0001, cin: 1'b0, sum: 16'h0002, carry: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 16'h1234, b: 16'h0FFF, cin: 1'b1, sum: 16'h2234, carry: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, carry: 1'b1, ovf: 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_carry", 32'(carry), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      single_op(vecs[i]);
    end

    // Back-to-back stream at full throughput.
    p0        = n_pop;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (S) @(posedge clk);
    #1;
    check("b2b_count", 32'(n_pop - p0), 32'd100);

    // Random backpressure with a producer that holds its offer until taken.
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
      end
      out_ready = 1'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    reset_mid(1'b1);
    reset_mid(1'b0);

    // Pipeline still works after the resets.
    single_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
